// File: rtl/core_inst_seq.sv
// ============================================================================
// core_inst_seq
// ----------------------------------------------------------------------------
// Upstream instruction sequencer for the attention core. A single start pulse
// launches one complete run:
//   Q load -> K load -> kernel load -> execute -> drain wait ->
//   ofifo read into psum memory -> SFP accumulate -> SFP divide -> done
// Q and K rows arrive as a valid/ready stream and are forwarded to the core
// memories on mem_in. Every core operation is issued through the 21-bit inst
// word.
//
// inst and mem_in are registered. What appears on them in a given cycle was
// decided from the state and counter of the previous cycle.
//
// Parameters
//   pr         : Q/K lanes per mem_in beat
//   bw         : bits per lane
//   col        : number of K rows / MAC columns
//   drain_wait : idle cycles between the end of EXEC and the first ofifo read
//                (must be at least 1)
//
// Ports
//   clk       in   1      clock
//   reset     in   1      synchronous active-high reset
//   start     in   1      begin a run; only honoured in IDLE
//   cfg_len   in   5      number of Q rows n; 0 or >16 selects 16
//   in_valid  in   1      in_data beat valid
//   in_ready  out  1      sequencer accepts a beat (LOAD_Q / LOAD_K only)
//   in_data   in   pr*bw  Q/K row data
//   mem_in    out  pr*bw  registered data to the core memories
//   inst      out  21     registered core instruction word
//   busy      out  1      run in progress, up to and including the DONE cycle
//   done      out  1      one-cycle pulse in the DONE state
// ============================================================================
module core_inst_seq #(
    parameter int pr         = 16,
    parameter int bw         = 8,
    parameter int col        = 8,
    parameter int drain_wait = 24
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [4:0]         cfg_len,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [pr*bw-1:0]   in_data,
    output logic [pr*bw-1:0]   mem_in,
    output logic [20:0]        inst,
    output logic               busy,
    output logic               done
);

    // Instruction word field positions
    localparam int BIT_DIV      = 20;
    localparam int BIT_OFIFO_RD = 16;
    localparam int QK_ADD_HI    = 15;
    localparam int QK_ADD_LO    = 12;
    localparam int PM_ADD_HI    = 11;
    localparam int PM_ADD_LO    = 8;
    localparam int BIT_EXECUTE  = 7;
    localparam int BIT_KLOAD    = 6;
    localparam int BIT_QMEM_RD  = 5;
    localparam int BIT_QMEM_WR  = 4;
    localparam int BIT_KMEM_RD  = 3;
    localparam int BIT_KMEM_WR  = 2;
    localparam int BIT_PMEM_RD  = 1;
    localparam int BIT_PMEM_WR  = 0;

    // The shared counter has to reach the largest per-state count: col in
    // KLOAD, n (up to 16) in EXEC, drain_wait-1 in DRAIN.
    localparam int MAX_A   = (drain_wait > col) ? drain_wait : col;
    localparam int MAX_CNT = (MAX_A > 17) ? MAX_A : 17;
    localparam int CNT_W   = $clog2(MAX_CNT + 1);

    typedef enum logic [3:0] {
        IDLE   = 4'd0,
        LOAD_Q = 4'd1,
        LOAD_K = 4'd2,
        KLOAD  = 4'd3,
        EXEC   = 4'd4,
        DRAIN  = 4'd5,
        OREAD  = 4'd6,
        ACC    = 4'd7,
        DIV    = 4'd8,
        DONE   = 4'd9
    } state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [4:0]           runLen_q, runLen_d;
    logic [20:0]          inst_q, inst_d;
    logic [pr*bw-1:0]     memIn_q, memIn_d;

    logic                 accept;
    logic [CNT_W-1:0]     lenCnt;
    logic [3:0]           addr;
    logic [4:0]           cfgClamped;

    assign accept = in_valid & in_ready;
    assign lenCnt = CNT_W'(runLen_q);
    assign addr   = cnt_q[3:0];

    // A zero length and anything beyond the 16 Q rows the memories hold
    // both mean a full 16-row run.
    assign cfgClamped = ((cfg_len == 5'd0) || (cfg_len > 5'd16)) ? 5'd16 : cfg_len;

    assign inst   = inst_q;
    assign mem_in = memIn_q;

    // State register plus the registered inst/mem_in outputs. Reset drops
    // any run in progress; nothing resumes afterwards.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            runLen_q <= '0;
            inst_q   <= '0;
            memIn_q  <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            runLen_q <= runLen_d;
            inst_q   <= inst_d;
            memIn_q  <= memIn_d;
        end
    end

    // Next-state logic. The counter restarts at zero on every state entry.
    // In the load states it advances only on accepted beats, so stalls never
    // skip an address.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        runLen_d = runLen_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    runLen_d = cfgClamped;
                    cnt_d    = '0;
                    state_d  = LOAD_Q;
                end
            end
            LOAD_Q: begin
                if (accept) begin
                    if (cnt_q == lenCnt - CNT_W'(1)) begin
                        cnt_d   = '0;
                        state_d = LOAD_K;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            LOAD_K: begin
                if (accept) begin
                    if (cnt_q == CNT_W'(col - 1)) begin
                        cnt_d   = '0;
                        state_d = KLOAD;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            KLOAD: begin
                // col reads plus one extra cycle for SRAM read latency
                if (cnt_q == CNT_W'(col)) begin
                    cnt_d   = '0;
                    state_d = EXEC;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            EXEC: begin
                // n Q reads plus one trailing execute-only cycle
                if (cnt_q == lenCnt) begin
                    cnt_d   = '0;
                    state_d = DRAIN;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DRAIN: begin
                if (cnt_q == CNT_W'(drain_wait - 1)) begin
                    cnt_d   = '0;
                    state_d = OREAD;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            OREAD: begin
                if (cnt_q == lenCnt - CNT_W'(1)) begin
                    cnt_d   = '0;
                    state_d = ACC;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ACC: begin
                if (cnt_q == lenCnt - CNT_W'(1)) begin
                    cnt_d   = '0;
                    state_d = DIV;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DIV: begin
                cnt_d   = '0;
                state_d = DONE;
            end
            DONE: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    // Output logic. inst_d/memIn_d are the values presented one cycle later.
    // mem_in holds its last beat between loads.
    always_comb begin
        in_ready = 1'b0;
        busy     = (state_q != IDLE);
        done     = (state_q == DONE);
        inst_d   = '0;
        memIn_d  = memIn_q;
        case (state_q)
            LOAD_Q: begin
                in_ready = 1'b1;
                if (accept) begin
                    inst_d[BIT_QMEM_WR]            = 1'b1;
                    inst_d[QK_ADD_HI:QK_ADD_LO]    = addr;
                    memIn_d                        = in_data;
                end
            end
            LOAD_K: begin
                in_ready = 1'b1;
                if (accept) begin
                    inst_d[BIT_KMEM_WR]            = 1'b1;
                    inst_d[QK_ADD_HI:QK_ADD_LO]    = addr;
                    memIn_d                        = in_data;
                end
            end
            KLOAD: begin
                inst_d[BIT_KLOAD] = 1'b1;
                if (cnt_q < CNT_W'(col)) begin
                    inst_d[BIT_KMEM_RD]            = 1'b1;
                    inst_d[QK_ADD_HI:QK_ADD_LO]    = addr;
                end
            end
            EXEC: begin
                inst_d[BIT_EXECUTE] = 1'b1;
                if (cnt_q < lenCnt) begin
                    inst_d[BIT_QMEM_RD]            = 1'b1;
                    inst_d[QK_ADD_HI:QK_ADD_LO]    = addr;
                end
            end
            OREAD: begin
                // ofifo pop and psum write happen in the same cycle
                inst_d[BIT_OFIFO_RD]               = 1'b1;
                inst_d[BIT_PMEM_WR]                = 1'b1;
                inst_d[PM_ADD_HI:PM_ADD_LO]        = addr;
            end
            ACC: begin
                inst_d[BIT_PMEM_RD]                = 1'b1;
                inst_d[PM_ADD_HI:PM_ADD_LO]        = addr;
            end
            DIV: begin
                inst_d[BIT_DIV] = 1'b1;
            end
            default: begin
                inst_d = '0;
            end
        endcase
    end

endmodule

// File: doc/core_inst_seq.md
Name: core_inst_seq

Overview:
- Upstream instruction sequencer for the attention core.
- Accepts a streamed Q/K data burst over a valid/ready handshake.
- Drives the core's 21-bit `inst` word and `mem_in` bus through the full flow: Q load, K load, kernel load, execute, ofifo drain to psum mem, SFP accumulate, SFP divide.
- Started by a single `start` pulse; reports `busy` and a one-cycle `done`.

Parameters:
- pr, 16, number of Q/K lanes (words per `mem_in` beat)
- bw, 8, bits per lane
- col, 8, number of K rows / MAC columns
- drain_wait, 24, idle cycles between end of EXEC and first ofifo read

Ports:
- clk  input  1  clock
- reset  input  1  synchronous active-high reset
- start  input  1  begin a run; sampled only in IDLE
- cfg_len  input  5  number of Q rows n; latched on accepted start
- in_valid  input  1  `in_data` beat valid
- in_ready  output  1  sequencer can accept a beat
- in_data  input  pr*bw  Q/K row data
- mem_in  output  pr*bw  registered data to core memories
- inst  output  21  registered core instruction word
- busy  output  1  high from the cycle after an accepted start until the DONE cycle inclusive
- done  output  1  one-cycle pulse in DONE

Behaviour:
- One clock. Reset is synchronous, active-high.
- Reset values: inst=0, mem_in=0, in_ready=0, busy=0, done=0, state=IDLE, counters=0.
- Reset asserted mid-run returns to IDLE with all outputs zero at the next edge. No partial sequence resumes.
- inst fields (all other bits 0):
  - [20] div
  - [16] ofifo_rd
  - [15:12] qkmem_add
  - [11:8] pmem_add
  - [7] execute
  - [6] kernel load / kmem select
  - [5] qmem_rd, [4] qmem_wr, [3] kmem_rd, [2] kmem_wr, [1] pmem_rd, [0] pmem_wr
- inst and mem_in are registered. Each reflects the state/counter of the previous cycle.
- cfg_len latch: n = cfg_len; a value of 0 or >16 is clamped to 16.
- start while busy is ignored.
- States (i = cycle/beat counter, reset to 0 on each state entry):
  - IDLE: in_ready=0. start → LOAD_Q.
  - LOAD_Q: in_ready=1. Each in_valid&in_ready beat produces next-cycle inst[4]=1, qkmem_add=i, mem_in=in_data, then i++. No beat gives an inst all-zero cycle (stall). After n beats → LOAD_K.
  - LOAD_K: same as LOAD_Q with inst[2] (kmem_wr). After col beats → KLOAD; in_ready deasserts in that same cycle.
  - KLOAD: col+1 cycles.
    - i<col: inst[3]=1, inst[6]=1, qkmem_add=i.
    - Final cycle: inst[6]=1 only, covering SRAM read latency.
    - Then → EXEC.
  - EXEC: n+1 cycles.
    - i<n: inst[5]=1, inst[7]=1, qkmem_add=i.
    - Final cycle: inst[7]=1 only.
    - Then → DRAIN.
  - DRAIN: drain_wait cycles, inst=0 → OREAD.
  - OREAD: n cycles, inst[16]=1, inst[0]=1, pmem_add=i (same-cycle ofifo pop and psum write) → ACC.
  - ACC: n cycles, inst[1]=1, pmem_add=i → DIV.
  - DIV: 1 cycle, inst[20]=1 → DONE.
  - DONE: 1 cycle, done=1, inst=0 → IDLE.
- Address counters are 4 bits. i counts 0..n-1 and never wraps within a state.
- Fixed latency from the last K beat accepted to done high: (col+1)+(n+1)+drain_wait+2n+2 cycles.
  - With defaults and n=16: 9+17+24+34 = 84.
- in_valid outside LOAD_Q/LOAD_K is ignored; no data is consumed.

Test Plan:
- Reset then idle 5 cycles → inst=0, mem_in=0, in_ready=0, busy=0, done=0 throughout.
- start, cfg_len=16, 24 back-to-back beats (data = beat index) → 16 inst words with bit4 and qkmem_add 0..15, then 8 with bit2 and addr 0..7; mem_in matches each beat one cycle later. done is high exactly 84 cycles after the last beat.
- Same run with in_valid deasserted on every other cycle → inst=0 on stall cycles; addresses still increment only on accepted beats; same post-load latency.
- cfg_len=0 and cfg_len=20 → both behave as n=16. cfg_len=4 → EXEC issues qkmem_add 0..3 plus one bit7-only cycle; OREAD and ACC are 4 cycles each; done 9+5+24+10=48 cycles after the last K beat.
- start pulsed during EXEC → ignored; cfg_len changed mid-run → no effect on the current run.
- reset asserted for one cycle in OREAD → next cycle inst=0, busy=0. A fresh start then runs a full correct sequence.
